// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with HI/LO result registers.
// Results are computed from operands latched at issue and written when the latency counter expires.
module mult_div_unit #(
    parameter int unsigned MULT_CYC = 5,
    parameter int unsigned DIV_CYC  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        cancel,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic        busy_q, busy_d;

    logic        issue;
    logic [63:0] prod_s, prod_u;
    logic [31:0] abs_a, abs_b, q_mag, r_mag, quo_s, rem_s, quo_u, rem_u;

    assign issue = start & ~cancel & ~busy_q;

    always_comb begin
        prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
        prod_u = {32'd0, a_q} * {32'd0, b_q};
        // Signed divide on magnitudes so 0x80000000 / -1 wraps instead of overflowing
        abs_a  = a_q[31] ? (32'd0 - a_q) : a_q;
        abs_b  = b_q[31] ? (32'd0 - b_q) : b_q;
        q_mag  = (abs_b != 32'd0) ? abs_a / abs_b : 32'd0;
        r_mag  = (abs_b != 32'd0) ? abs_a % abs_b : 32'd0;
        quo_s  = (a_q[31] ^ b_q[31]) ? (32'd0 - q_mag) : q_mag;
        rem_s  = a_q[31] ? (32'd0 - r_mag) : r_mag;
        quo_u  = (b_q != 32'd0) ? a_q / b_q : 32'd0;
        rem_u  = (b_q != 32'd0) ? a_q % b_q : 32'd0;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        busy_d  = busy_q;
        case (state_q)
            IDLE: begin
                if (issue) begin
                    case (op)
                        3'd0, 3'd1, 3'd2, 3'd3: begin
                            a_d     = A;
                            b_d     = B;
                            op_d    = op[1:0];
                            cnt_d   = op[1] ? 4'(DIV_CYC) : 4'(MULT_CYC);
                            state_d = RUN;
                            busy_d  = 1'b1;
                        end
                        3'd4:    hi_d = A;
                        3'd5:    lo_d = A;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    case (op_q)
                        2'd0: {hi_d, lo_d} = prod_s;
                        2'd1: {hi_d, lo_d} = prod_u;
                        // Divide by zero leaves HI/LO untouched
                        2'd2: if (b_q != 32'd0) begin
                            hi_d = rem_s;
                            lo_d = quo_s;
                        end
                        2'd3: if (b_q != 32'd0) begin
                            hi_d = rem_u;
                            lo_d = quo_u;
                        end
                        default: ;
                    endcase
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            op_q    <= 2'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
        end
    end

    assign busy = busy_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed table, multi-cycle corner sequences,
// then randomized ops checked against a 64-bit arithmetic reference model.
module tb_mult_div_unit;

    localparam int MULT_CYC = 5;
    localparam int DIV_CYC  = 10;
    localparam int BOUND    = 40;

    logic        clk = 1'b0;
    logic        reset, start, cancel;
    logic [2:0]  op;
    logic [31:0] A, B;
    logic        busy;
    logic [31:0] HI, LO;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] m_hi, m_lo;

    mult_div_unit #(.MULT_CYC(MULT_CYC), .DIV_CYC(DIV_CYC)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
        .cancel(cancel), .busy(busy), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a, b;
        int          lat;
        logic [31:0] hi, lo;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Reference: whole-word arithmetic in 64 bits; returns expected busy cycles
    function automatic int model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, sp, sq, sr;
        longint unsigned up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            3'd0: begin sp = sa * sb; m_hi = sp[63:32]; m_lo = sp[31:0]; return MULT_CYC; end
            3'd1: begin up = 64'(a) * 64'(b); m_hi = up[63:32]; m_lo = up[31:0]; return MULT_CYC; end
            3'd2: begin
                if (b != 0) begin sq = sa / sb; sr = sa % sb; m_hi = sr[31:0]; m_lo = sq[31:0]; end
                return DIV_CYC;
            end
            3'd3: begin
                if (b != 0) begin m_hi = a % b; m_lo = a / b; end
                return DIV_CYC;
            end
            3'd4: begin m_hi = a; return 0; end
            3'd5: begin m_lo = a; return 0; end
            default: return 0;
        endcase
    endfunction

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input logic c);
        start = 1'b1; op = o; A = a; B = b; cancel = c;
        @(posedge clk); #1;
        start = 1'b0; cancel = 1'b0;
    endtask

    // Counts busy-high samples; operands are scrambled to show they are not reused
    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (busy === 1'b1 && cyc < BOUND) begin
            cyc++;
            A = $urandom; B = $urandom;
            @(posedge clk); #1;
        end
    endtask

    task automatic run_chk(input string name, input logic [2:0] o, input logic [31:0] a,
                           input logic [31:0] b, input logic c);
        int lat, cyc;
        lat = c ? 0 : model(o, a, b);
        issue(o, a, b, c);
        wait_idle(cyc);
        chk({name, " busy_cycles"}, 32'(cyc), 32'(lat));
        chk({name, " HI"}, HI, m_hi);
        chk({name, " LO"}, LO, m_lo);
    endtask

    vec_t tbl[10];

    initial begin
        int cyc, lat;
        tbl[0] = '{"mult_neg2x3",   3'd0, 32'hFFFFFFFE, 32'd3,        5,  32'hFFFFFFFF, 32'hFFFFFFFA};
        tbl[1] = '{"multu_max",     3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5,  32'hFFFFFFFE, 32'h00000001};
        tbl[2] = '{"div_m7_2",      3'd2, 32'hFFFFFFF9, 32'd2,        10, 32'hFFFFFFFF, 32'hFFFFFFFD};
        tbl[3] = '{"divu_by0",      3'd3, 32'd7,        32'd0,        10, 32'hFFFFFFFF, 32'hFFFFFFFD};
        tbl[4] = '{"div_ovf",       3'd2, 32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000};
        tbl[5] = '{"mthi",          3'd4, 32'h12345678, 32'd0,        0,  32'h12345678, 32'h80000000};
        tbl[6] = '{"mtlo",          3'd5, 32'hCAFEBABE, 32'd0,        0,  32'h12345678, 32'hCAFEBABE};
        tbl[7] = '{"divu_100_7",    3'd3, 32'd100,      32'd7,        10, 32'h00000002, 32'h0000000E};
        tbl[8] = '{"div_7_m2",      3'd2, 32'd7,        32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD};
        tbl[9] = '{"reserved_op6",  3'd6, 32'h55555555, 32'h1,        0,  32'h00000001, 32'hFFFFFFFD};

        reset = 1'b1; start = 1'b0; cancel = 1'b0; op = 3'd0; A = '0; B = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset HI", HI, 32'd0);
        chk("reset LO", LO, 32'd0);
        m_hi = 0; m_lo = 0;

        foreach (tbl[i]) begin
            lat = model(tbl[i].op, tbl[i].a, tbl[i].b);
            issue(tbl[i].op, tbl[i].a, tbl[i].b, 1'b0);
            wait_idle(cyc);
            chk({tbl[i].name, " busy_cycles"}, 32'(cyc), 32'(tbl[i].lat));
            chk({tbl[i].name, " HI"}, HI, tbl[i].hi);
            chk({tbl[i].name, " LO"}, LO, tbl[i].lo);
        end

        // Cancelled issues change nothing
        run_chk("mtlo_cancel", 3'd5, 32'hDEADBEEF, 32'd0, 1'b1);
        run_chk("mult_cancel", 3'd0, 32'd9, 32'd9, 1'b1);

        // Second start while busy is dropped
        lat = model(3'd0, 32'd3, 32'd4);
        issue(3'd0, 32'd3, 32'd4, 1'b0);
        start = 1'b1; op = 3'd0; A = 32'd5; B = 32'd6;
        @(posedge clk); #1;
        start = 1'b0;
        wait_idle(cyc);
        chk("busy_start busy_cycles", 32'(cyc + 1), 32'(lat));
        chk("busy_start HI", HI, 32'd0);
        chk("busy_start LO", LO, 32'd12);

        // Cancel during RUN does not abort
        lat = model(3'd0, 32'd7, 32'd9);
        issue(3'd0, 32'd7, 32'd9, 1'b0);
        cancel = 1'b1;
        repeat (2) @(posedge clk);
        #1 cancel = 1'b0;
        wait_idle(cyc);
        chk("cancel_run busy_cycles", 32'(cyc + 2), 32'(lat));
        chk("cancel_run LO", LO, 32'd63);

        // Reset in cycle 3 of a divide
        issue(3'd2, 32'd100, 32'd3, 1'b0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("rst_mid busy", 32'(busy), 32'd0);
        chk("rst_mid HI", HI, 32'd0);
        chk("rst_mid LO", LO, 32'd0);
        m_hi = 0; m_lo = 0;
        run_chk("post_rst_mult", 3'd0, 32'd2, 32'd3, 1'b0);

        for (int i = 0; i < 60; i++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = 32'd0;
                1:       rb = $urandom_range(1, 20);
                2:       rb = 32'hFFFFFFFF;
                default: rb = $urandom;
            endcase
            run_chk($sformatf("rand%0d", i), 3'($urandom_range(0, 7)), ra, rb,
                    ($urandom_range(0, 7) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset.
REQ-002 SHALL use the following parameters: MULT_CYC, default 5, multiply latency in cycles; DIV_CYC, default 10, divide latency in cycles.
REQ-003 SHALL have port clk, input, 1 bit: rising-edge clock; all state changes occur on this edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: qualifies op; an operation is issued in a cycle where this is 1.
REQ-006 SHALL have port op, input, 3 bits: 0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6-7 reserved (no-op).
REQ-007 SHALL have port A, input, 32 bits: E-stage forwarded rs value.
REQ-008 SHALL have port B, input, 32 bits: E-stage forwarded rt value.
REQ-009 SHALL have port cancel, input, 1 bit: exception/eret flush from the M stage; suppresses issue in the same cycle.
REQ-010 SHALL have port busy, output, 1 bit: registered; high while a multiply or divide is in flight.
REQ-011 SHALL have port HI, output, 32 bits: registered HI.
REQ-012 SHALL have port LO, output, 32 bits: registered LO.

Function
REQ-013 SHALL accept an issue only when start=1 & cancel=0 & busy=0; otherwise start is ignored and no state changes.
REQ-014 SHALL use two states, IDLE and RUN, plus a 4-bit down-counter cnt.
REQ-015 SHALL, on an accepted mult/multu/div/divu in IDLE: latch A, B and op internally; load cnt with MULT_CYC or DIV_CYC; go to RUN; set busy=1 at that edge.
REQ-016 SHALL, in RUN, decrement cnt by 1 each edge; when cnt=1 at an edge, write HI/LO, go to IDLE and set busy=0 at that same edge.
REQ-017 SHALL, as a result, hold busy high for exactly MULT_CYC (or DIV_CYC) cycles after the issuing edge, with HI/LO updated at the edge on which busy falls.
REQ-018 SHALL keep HI/LO holding their old values while busy=1 (no partial results visible).
REQ-019 SHALL compute mult as the signed 32x32 -> 64-bit product: HI = product[63:32], LO = product[31:0].
REQ-020 SHALL compute multu as the same split with both operands unsigned.
REQ-021 SHALL compute div as signed division: LO = quotient truncated toward zero, HI = remainder with the sign of the dividend.
REQ-022 SHALL compute divu as unsigned division: LO = quotient, HI = remainder.
REQ-023 SHALL, for div/divu with B=0, still run the full DIV_CYC cycles and leave HI/LO unchanged at completion.
REQ-024 SHALL, for div with 0x80000000 / 0xFFFFFFFF, produce LO = 0x80000000 and HI = 0 (wrap, no trap).
REQ-025 SHALL, on an accepted mthi or mtlo, write HI<=A or LO<=A at that edge; busy stays 0; no RUN entry.
REQ-026 SHALL treat reserved op values 6-7 with start=1 as no-ops.
REQ-027 SHALL ignore start with cancel=1 (including mthi/mtlo), with no HI/LO or state change.
REQ-028 SHALL NOT abort an operation already in RUN when cancel is asserted; it completes normally.
REQ-029 SHALL ignore start=1 while busy=1; the external stall covers mfhi/mflo/mt*/md while (start|busy).
REQ-030 SHALL compute results from the latched operands; A/B changes during RUN have no effect.

Reset
REQ-031 SHALL, when reset=1 at an edge, set HI=0, LO=0, busy=0, cnt=0 and state=IDLE, and clear the latched operands.
REQ-032 SHALL give reset priority over start and cancel.
REQ-033 SHALL abandon an in-flight operation if reset is asserted mid-RUN; HI/LO are 0 afterwards.
REQ-034 SHALL make the outputs valid from the first edge after reset is deasserted, accepting issues from the next cycle.

Verification
REQ-035 SHALL cover: mult A=0xFFFFFFFE, B=3 -> busy high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-036 SHALL cover: multu A=0xFFFFFFFF, B=0xFFFFFFFF -> after 5 cycles HI=0xFFFFFFFE, LO=0x00000001.
REQ-037 SHALL cover: div A=0xFFFFFFF9 (-7), B=2 -> busy high 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF; then divu A=7, B=0 -> after 10 cycles HI/LO unchanged.
REQ-038 SHALL cover: mthi A=0x12345678 -> HI=0x12345678 next edge, busy stays 0; mtlo with cancel=1 -> LO unchanged.
REQ-039 SHALL cover: start mult while busy=1 with different operands -> ignored, result reflects the first op only.
REQ-040 SHALL cover: reset asserted in cycle 3 of a div -> busy=0, HI=LO=0 next edge; a new mult issued afterwards completes in 5 cycles.
